ram_ctrl: RTL

RAM_CTRL -- requirements
Module: ram_ctrl

---
 rtl/ram_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/ram_ctrl.sv
// Single-port word RAM controller with byte-enable writes, pipelined reads
// (1 or 2 cycle latency), out-of-range error reporting and optional zero-fill after reset.
module ram_ctrl #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned DEPTH          = 16384,
  parameter int unsigned RD_LAT         = 1,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req,
  input  logic                we,
  input  logic [31:0]         address,
  input  logic [DATA_W-1:0]   ram_in,
  input  logic [DATA_W/8-1:0] be,
  output logic                ready,
  output logic                rvalid,
  output logic [DATA_W-1:0]   ram_out,
  output logic                err
);

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned NB        = DATA_W / 8;
  localparam bit          TWO_STAGE = (RD_LAT == 2);
  localparam bit          CLEAR_EN  = (CLEAR_ON_RESET != 0);

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t            state, state_next;
  logic [AW-1:0]     clr_ptr, clr_ptr_next;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0]     idx_c;
  logic              oor_c;
  logic              acc_c;
  logic              rd_acc_c;
  logic              wr_acc_c;
  logic [DATA_W-1:0] rd_data_c;

  logic              mem_we_c;
  logic [AW-1:0]     mem_addr_c;
  logic [DATA_W-1:0] mem_data_c;
  logic [NB-1:0]     mem_be_c;

  logic              s1_v;
  logic              s1_oor;
  logic [DATA_W-1:0] s1_data;

  logic              out_v_c;
  logic              out_oor_c;
  logic [DATA_W-1:0] out_data_c;

  // Upper address bits only feed the range check so they can never alias.
  assign idx_c     = address[AW-1:0];
  assign oor_c     = |address[ADDR_W-1:AW];
  assign acc_c     = req && ready;
  assign rd_acc_c  = acc_c && !we;
  assign wr_acc_c  = acc_c && we;
  assign rd_data_c = oor_c ? '0 : mem[idx_c];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= INIT;
      clr_ptr <= '0;
      ready   <= 1'b0;
    end else begin
      state   <= state_next;
      clr_ptr <= clr_ptr_next;
      ready   <= (state_next == RUN);
    end
  end

  always_comb begin
    state_next   = state;
    clr_ptr_next = clr_ptr;
    mem_we_c     = 1'b0;
    mem_addr_c   = idx_c;
    mem_data_c   = ram_in;
    mem_be_c     = be;
    case (state)
      INIT: begin
        if (!CLEAR_EN) begin
          state_next = RUN;
        end else begin
          mem_we_c     = 1'b1;
          mem_addr_c   = clr_ptr;
          mem_data_c   = '0;
          mem_be_c     = '1;
          clr_ptr_next = clr_ptr + AW'(1);
          if (clr_ptr == AW'(DEPTH - 1)) state_next = RUN;
        end
      end
      RUN: begin
        mem_we_c = wr_acc_c && !oor_c;
      end
      default: state_next = INIT;
    endcase
  end

  // Array has no reset; reset only blocks writes, contents change via INIT fill.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we_c) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_be_c[i]) mem[mem_addr_c][8*i +: 8] <= mem_data_c[8*i +: 8];
      end
    end
  end

  // Optional first read stage, only observed when RD_LAT is 2.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_oor  <= 1'b0;
      s1_data <= '0;
    end else begin
      s1_v   <= rd_acc_c;
      s1_oor <= rd_acc_c && oor_c;
      if (rd_acc_c) s1_data <= rd_data_c;
    end
  end

  assign out_v_c    = TWO_STAGE ? s1_v    : rd_acc_c;
  assign out_oor_c  = TWO_STAGE ? s1_oor  : (rd_acc_c && oor_c);
  assign out_data_c = TWO_STAGE ? s1_data : rd_data_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rvalid  <= 1'b0;
      err     <= 1'b0;
      ram_out <= '0;
    end else begin
      rvalid <= out_v_c;
      err    <= out_oor_c || (wr_acc_c && oor_c);
      if (out_v_c) ram_out <= out_data_c;
    end
  end

endmodule
